// File: rtl/uart_rx_word_packer_if.sv
// uart_rx_word_packer_if: byte-in / word-out bundle between the UART receiver, the packer and the word consumer
// master drives rx_data/rx_done and observes results; slave is the packer itself.
interface uart_rx_word_packer_if #(parameter int DATA_BYTES = 8);
  logic [7:0] rx_data;
  logic rx_done;
  logic [8*DATA_BYTES-1:0] data_out_64;
  logic data_out_done;
  logic busy;
  logic frame_err;
  logic chk_err;
  modport master(output rx_data, rx_done, input data_out_64, data_out_done, busy, frame_err, chk_err);
  modport slave(input rx_data, rx_done, output data_out_64, data_out_done, busy, frame_err, chk_err);
endinterface

// File: rtl/uart_rx_word_packer.sv
// uart_rx_word_packer: packs received UART bytes MSB-first into a DATA_BYTES word, dropping partial words on inter-byte timeout
// Ports: clk, rst (sync, active-high); bus.rx_data/rx_done in; bus.data_out_64, data_out_done, busy, frame_err, chk_err out.
// Optional macro PACKER_CHECKSUM_EN: expects a trailing XOR checksum byte per word, mismatch pulses chk_err.
module uart_rx_word_packer #(
  parameter int DATA_BYTES = 8,
  parameter int TIMEOUT_CYCLES = 43400
) (
  input logic clk,
  input logic rst,
  uart_rx_word_packer_if.slave bus
);
  localparam int W = 8 * DATA_BYTES;
  localparam int CW = $clog2(DATA_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PACKER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
  logic [7:0] xacc;
  logic cerr_q;
`else
  typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif
  state_t state;
  logic [W-1:0] shreg, data_q, next_sh;
  logic [CW-1:0] byte_cnt, next_cnt;
  logic [TW-1:0] timer;
  logic done_q, ferr_q, last, timeout;
  always_comb begin
    next_sh = ((state == IDLE) ? '0 : (shreg << 8)) | W'(bus.rx_data);
    next_cnt = (state == IDLE) ? CW'(1) : byte_cnt + 1'b1;
    last = next_cnt == CW'(DATA_BYTES);
    timeout = timer == TW'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      byte_cnt <= '0;
      timer <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef PACKER_CHECKSUM_EN
      xacc <= '0;
      cerr_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef PACKER_CHECKSUM_EN
      cerr_q <= 1'b0;
`endif
      if (bus.rx_done) begin
        timer <= '0;
`ifdef PACKER_CHECKSUM_EN
        if (state == CHECK) begin
          state <= IDLE;
          byte_cnt <= '0;
          if (bus.rx_data == xacc) begin
            data_q <= shreg;
            done_q <= 1'b1;
          end else cerr_q <= 1'b1;
        end else begin
          shreg <= next_sh;
          xacc <= ((state == IDLE) ? 8'h00 : xacc) ^ bus.rx_data;
          state <= last ? CHECK : RECV;
          byte_cnt <= last ? '0 : next_cnt;
        end
`else
        shreg <= next_sh;
        if (last) begin
          data_q <= next_sh;
          done_q <= 1'b1;
          state <= IDLE;
          byte_cnt <= '0;
        end else begin
          state <= RECV;
          byte_cnt <= next_cnt;
        end
`endif
      end else if (state != IDLE) begin
        if (timeout) begin
          state <= IDLE;
          ferr_q <= 1'b1;
          byte_cnt <= '0;
          timer <= '0;
        end else timer <= timer + 1'b1;
      end
    end
  end
  assign bus.data_out_64 = data_q;
  assign bus.data_out_done = done_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy = state != IDLE;
`ifdef PACKER_CHECKSUM_EN
  assign bus.chk_err = cerr_q;
`else
  assign bus.chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_word_packer.sv
// tb_uart_rx_word_packer: randomized scoreboard bench for uart_rx_word_packer against a byte-queue reference model
module tb_uart_rx_word_packer;
  localparam int N = 8;
  localparam int T = 1000;
  localparam int W = 8 * N;
`ifdef PACKER_CHECKSUM_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif
  typedef struct {
    int kind;
    logic [W-1:0] word;
    int cyc;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_word_packer_if #(.DATA_BYTES(N)) bus();
  uart_rx_word_packer #(.DATA_BYTES(N), .TIMEOUT_CYCLES(T)) dut(.clk(clk), .rst(rst), .bus(bus));
  ev_t expq[$];
  logic [7:0] cur[$];
  logic [W-1:0] last_word = '0;
  int last_acc = 0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask
  task automatic model_step();
    logic [W-1:0] w;
    logic [7:0] x;
    cyc++;
    if (rst) begin
      cur.delete();
      last_word = '0;
    end else if (bus.rx_done) begin
      cur.push_back(bus.rx_data);
      last_acc = cyc;
      if (cur.size() == NB) begin
        w = '0;
        x = '0;
        for (int i = 0; i < N; i++) begin
          w = (w << 8) | W'(cur[i]);
          x = x ^ cur[i];
        end
`ifdef PACKER_CHECKSUM_EN
        if (cur[N] != x) expq.push_back('{2, last_word, cyc});
        else begin
          last_word = w;
          expq.push_back('{0, w, cyc});
        end
`else
        last_word = w;
        expq.push_back('{0, w, cyc});
`endif
        cur.delete();
      end
    end else if (cur.size() != 0 && cyc - last_acc == T) begin
      expq.push_back('{1, last_word, cyc});
      cur.delete();
    end
  endtask
  task automatic monitor_step();
    ev_t e;
    int np;
    int dk;
    if (rst) return;
    chk("busy", W'(bus.busy), W'(cur.size() != 0));
    np = int'(bus.data_out_done) + int'(bus.frame_err) + int'(bus.chk_err);
    if (np > 1) chk("pulse_exclusive", W'(np), W'(1));
    if (np != 0) begin
      dk = bus.frame_err ? 1 : bus.chk_err ? 2 : 0;
      if (expq.size() == 0) chk("unexpected_pulse", W'({bus.data_out_done, bus.frame_err, bus.chk_err}), '0);
      else begin
        e = expq.pop_front();
        chk("pulse_kind", W'(dk), W'(e.kind));
        chk("pulse_cycle", W'(cyc), W'(e.cyc));
        chk("data_out_64", bus.data_out_64, e.word);
      end
    end
    while (expq.size() != 0 && expq[0].cyc <= cyc) begin
      e = expq.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_pulse kind=%0d due_cyc=%0d now=%0d", e.kind, e.cyc, cyc);
    end
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
  end
  initial forever begin
    @(negedge clk);
    monitor_step();
  end
  initial begin
    #900000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
  task automatic put(input logic [7:0] b, input int gap);
    @(posedge clk);
    #2;
    bus.rx_done = 1'b1;
    bus.rx_data = b;
    repeat (gap) begin
      @(posedge clk);
      #2;
      bus.rx_done = 1'b0;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      bus.rx_done = 1'b0;
    end
  endtask
  task automatic send_word(input logic [W-1:0] w, input int gap, input bit bad);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < N; i++) begin
      put(w[W-1-8*i -: 8], gap);
      x = x ^ w[W-1-8*i -: 8];
    end
`ifdef PACKER_CHECKSUM_EN
    put(x ^ {7'd0, bad}, gap);
`endif
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_data", bus.data_out_64, '0);
    chk("reset_flags", W'({bus.busy, bus.data_out_done, bus.frame_err, bus.chk_err}), '0);
  endtask
  initial begin
    logic [W-1:0] rw;
    int k;
    bus.rx_done = 1'b0;
    bus.rx_data = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_data", bus.data_out_64, '0);
    chk("reset_flags", W'({bus.busy, bus.data_out_done, bus.frame_err, bus.chk_err}), '0);
    send_word(64'h2d7e66091ed0a403, 433, 1'b0);
    idle(3);
    chk("t1_word", bus.data_out_64, 64'h2d7e66091ed0a403);
    send_word(64'hd253328dd2c0fc3c, 0, 1'b0);
    send_word(64'hd253328dd2c0fc3c, 0, 1'b0);
    idle(3);
    chk("t2_word", bus.data_out_64, 64'hd253328dd2c0fc3c);
    put(8'h11, 1);
    put(8'h22, 1);
    put(8'h33, 1);
    idle(T + 20);
    chk("t3_keep", bus.data_out_64, 64'hd253328dd2c0fc3c);
    send_word(64'h8162476652bdd1d0, 1, 1'b0);
    idle(3);
    chk("t3_word", bus.data_out_64, 64'h8162476652bdd1d0);
    for (int i = 0; i < 5; i++) put(8'(8'hA0 + i), 1);
    do_reset();
    send_word(64'h0123456789abcdef, 1, 1'b0);
    idle(3);
    chk("t4_word", bus.data_out_64, 64'h0123456789abcdef);
    put(8'hfe, 1);
    put(8'hdc, 1);
    put(8'hba, T - 1);
    put(8'h98, 1);
    for (int i = 0; i < NB - 4; i++) put(8'(8'h76 - i), 1);
    idle(3);
    chk("t5_word", bus.data_out_64[W-1:W-32], 32'hfedcba98);
`ifdef PACKER_CHECKSUM_EN
    send_word(64'h2d7e66091ed0a403, 2, 1'b0);
    idle(3);
    chk("t6_good", bus.data_out_64, 64'h2d7e66091ed0a403);
    send_word(64'h2d7e66091ed0a403 ^ 64'h1, 2, 1'b1);
    idle(3);
    chk("t6_bad_keep", bus.data_out_64, 64'h2d7e66091ed0a403);
`endif
    for (int r = 0; r < 25; r++) begin
      rw = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: begin
          k = $urandom_range(1, NB - 1);
          for (int i = 0; i < k; i++) put(8'($urandom), $urandom_range(1, 3));
          idle($urandom_range(T - 3, T + 3));
        end
        1: begin
          for (int i = 0; i < NB; i++) put(8'($urandom), (i == 3) ? $urandom_range(T - 2, T) : 1);
          idle(2);
        end
        default: send_word(rw, $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
      endcase
    end
    idle(T + 10);
    chk("queue_empty", W'(expq.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_word_packer.md
Name: uart_rx_word_packer

Overview:
Receive-side stage sitting directly downstream of the UART byte receiver and upstream of the 64-bit consumer (data_out_64 / data_out_done in top).
- Collects a stream of received bytes into one DATA_BYTES-wide word, MSB byte first.
- Publishes the word with a single-cycle done pulse.
- Discards partial words on an inter-byte timeout, so a lost byte cannot misalign every following word.

Parameters:
DATA_BYTES, 8, bytes per output word; output width = 8*DATA_BYTES.
TIMEOUT_CYCLES, 43400, idle clk cycles allowed between bytes of one word (about 10 byte times at 115200 baud, 50 MHz clk).

Ports:
clk  input  1  system clock, 50 MHz, rising edge.
rst  input  1  synchronous reset, active-high.
rx_data  input  8  byte from UART receiver; valid only when rx_done=1.
rx_done  input  1  one-cycle strobe, byte valid.
data_out_64  output  8*DATA_BYTES  last completely assembled word.
data_out_done  output  1  one-cycle pulse: data_out_64 updated this cycle.
busy  output  1  high while a partial word is held.
frame_err  output  1  one-cycle pulse: partial word discarded on timeout.
chk_err  output  1  one-cycle pulse: checksum mismatch (tied 0 without macro).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state is updated on the rising edge of clk.
- Reset: state=IDLE; shift register, byte_cnt, timer and running XOR cleared. data_out_64=0, data_out_done=0, busy=0, frame_err=0, chk_err=0.
- Reset mid-word: partial data is lost, with no error pulse.
- States:
  - IDLE: rx_done -> load byte into shift reg LSB, byte_cnt=1, timer=0 -> RECV. If DATA_BYTES==1, complete immediately (see word complete).
  - RECV: rx_done -> shift reg = {shift[..-8], rx_data}, byte_cnt++, timer=0.
  - Word complete: on the DATA_BYTES-th byte -> data_out_64 <= assembled word and data_out_done=1 in the next cycle (latency 1 clk after final rx_done); return to IDLE (or CHECK with macro).
  - Timeout: no rx_done -> timer++. If the last accepted byte was at cycle t and there is no rx_done in cycles t+1..t+TIMEOUT_CYCLES, frame_err=1 in cycle t+TIMEOUT_CYCLES+1. Partial word discarded, state -> IDLE, data_out_64 unchanged.
- Simultaneous rx_done and timeout cycle: rx_done wins, byte is accepted, timer cleared.
- byte_cnt width is clog2(DATA_BYTES+1); it never wraps (cleared on completion).
- busy=1 exactly while state≠IDLE.
- Byte arriving in the same cycle data_out_done is high: IDLE behaviour, starts the next word. No byte is dropped.
- data_out_64 is never partially updated. It holds its value until the next complete word.
- data_out_done, frame_err and chk_err are mutually exclusive and never high two consecutive cycles from the same event.
- Timer saturates at TIMEOUT_CYCLES; it does not count in IDLE.

Optional Feature:
PACKER_CHECKSUM_EN
- Defined:
  - After DATA_BYTES data bytes the FSM enters CHECK and waits for one more byte, the XOR of all data bytes (running XOR kept in RECV).
  - Match -> data_out_64 updated and data_out_done pulse 1 cycle after the checksum byte.
  - Mismatch -> chk_err pulse 1 cycle later, data_out_64 unchanged, state IDLE.
  - Timeout rules apply in CHECK, with frame_err.
  - busy is high in CHECK.
- Undefined: no CHECK state, no XOR logic, chk_err tied 0, word completes on the DATA_BYTES-th byte.

Test Plan:
1. Reset; bytes 2d,7e,66,09,1e,d0,a4,03, one rx_done every 4340 cycles -> data_out_64=64'h2d7e66091ed0a403, data_out_done high exactly 1 cycle after the 8th rx_done, busy low from that cycle.
2. 16 rx_done strobes on consecutive cycles, bytes d2,53,32,8d,d2,c0,fc,3c twice -> two done pulses 8 cycles apart, both words 64'hd253328dd2c0fc3c. The 9th byte, coincident with the first done, is accepted.
3. Three bytes then silence -> frame_err high exactly TIMEOUT_CYCLES+1 cycles after the 3rd rx_done, data_out_64 unchanged. Then 8 bytes 81,62,47,66,52,bd,d1,d0 -> 64'h8162476652bdd1d0.
4. rst pulsed for 1 cycle after 5 bytes -> all outputs 0, no frame_err. The next 8 bytes form a correct word.
5. Next byte rx_done lands exactly TIMEOUT_CYCLES cycles after the previous one -> accepted, no frame_err, word completes normally.
6. With PACKER_CHECKSUM_EN: bytes of test 1 plus 55 -> done with 64'h2d7e66091ed0a403. Same bytes plus 54 -> chk_err pulse, no done, data_out_64 keeps its old value.
